// File: rtl/dmem_pkg.sv
// Shared definitions for the data-cache refill controller: opcodes, tag layout, FSM states.
package dmem_pkg;

  localparam logic [6:0] OP_LDB = 7'h10;
  localparam logic [6:0] OP_LDW = 7'h11;
  localparam logic [6:0] OP_STB = 7'h12;
  localparam logic [6:0] OP_STW = 7'h13;
  localparam logic [6:0] OP_NOP = 7'h3F;

  localparam int unsigned TAG_W         = 9;
  localparam int unsigned TAG_VALID     = 0;
  localparam int unsigned TAG_LINE_LSB  = 2;
  localparam int unsigned TAG_LINE_MSB  = 4;
  localparam int unsigned TAG_AGE_LSB   = 5;
  localparam int unsigned TAG_AGE_MSB   = 7;
  localparam int unsigned LINE_W        = 128;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FILL
  } state_e;

  function automatic logic is_load(input logic [6:0] op);
    return (op == OP_LDB) || (op == OP_LDW);
  endfunction

  // Fresh fill: valid set, age cleared, line index in its field, spare bits zero.
  function automatic logic [TAG_W-1:0] make_tag(input logic [2:0] line);
    logic [TAG_W-1:0] t;
    t = '0;
    t[TAG_VALID] = 1'b1;
    t[TAG_LINE_MSB:TAG_LINE_LSB] = line;
    t[TAG_AGE_MSB:TAG_AGE_LSB] = 3'b000;
    return t;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// 32x32-bit backing store: one word write port, one combinational 128-bit line read port.
module dmem_line_array
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        ridx_i,
  output logic [LINE_W-1:0] rline_o
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        mem_q[i] <= 32'(i);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rline_o = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      rline_o[32*k +: 32] = mem_q[{ridx_i, 2'(k)}];
    end
  end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill controller: captures load misses, waits MEM_LATENCY cycles,
// then presents a one-cycle registered line fill; stores write through to backing memory.
module dcache_refill_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        mem_op,
  input  logic              dcache_miss,
  input  logic [4:0]        miss_addr,
  input  logic              st_valid,
  input  logic [4:0]        st_addr,
  input  logic [31:0]       st_data,
  output logic              wdcache,
  output logic [LINE_W-1:0] wdcacheline,
  output logic [TAG_W-1:0]  wdcachetag,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          line_q, line_d;
  logic                wdcache_q, wdcache_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [TAG_W-1:0]    wtag_q, wtag_d;
  logic [LINE_W-1:0]   rd_line;
  logic [LINE_W-1:0]   merged_line;

  dmem_line_array u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (st_valid),
    .waddr_i (st_addr),
    .wdata_i (st_data),
    .ridx_i  (line_q),
    .rline_o (rd_line)
  );

  // The array read shows pre-store contents this cycle, so a same-cycle store
  // into the captured line is forwarded here to keep the fill current.
  always_comb begin
    merged_line = rd_line;
    for (int unsigned k = 0; k < 4; k++) begin
      if (st_valid && (st_addr == {line_q, 2'(k)})) begin
        merged_line[32*k +: 32] = st_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    wdcache_d = 1'b0;
    wline_d   = wline_q;
    wtag_d    = wtag_q;
    unique case (state_q)
      IDLE: begin
        if (dcache_miss && is_load(mem_op)) begin
          line_d  = miss_addr[4:2];
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = FILL;
          wdcache_d = 1'b1;
          wline_d   = merged_line;
          wtag_d    = make_tag(line_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      line_q    <= '0;
      wdcache_q <= 1'b0;
      wline_q   <= '0;
      wtag_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      wdcache_q <= wdcache_d;
      wline_q   <= wline_d;
      wtag_q    <= wtag_d;
    end
  end

  assign wdcache     = wdcache_q;
  assign wdcacheline = wline_q;
  assign wdcachetag  = wtag_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl: default latency instance plus a MEM_LATENCY=1 instance.
module tb_dcache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   mem_op;
  logic         dcache_miss;
  logic [4:0]   miss_addr;
  logic         st_valid;
  logic [4:0]   st_addr;
  logic [31:0]  st_data;

  logic         wd0, wd1;
  logic [127:0] line0, line1;
  logic [8:0]   tag0, tag1;
  logic         busy0, busy1;

  int checks = 0;
  int failures = 0;

  dcache_refill_ctrl #(.MEM_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .dcache_miss(dcache_miss), .miss_addr(miss_addr),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .wdcache(wd0), .wdcacheline(line0), .wdcachetag(tag0), .busy(busy0)
  );

  dcache_refill_ctrl #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .mem_op(mem_op), .dcache_miss(dcache_miss), .miss_addr(miss_addr),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .wdcache(wd1), .wdcacheline(line1), .wdcachetag(tag1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present_miss(input logic [4:0] a, input logic [6:0] op);
    miss_addr = a; mem_op = op; dcache_miss = 1'b1;
    tick();
    dcache_miss = 1'b0; mem_op = 7'h3F;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (wd0 !== 1'b0) begin failures++; $display("FAIL reset_wdcache got=%b exp=0", wd0); end
    checks++; if (line0 !== 128'd0) begin failures++; $display("FAIL reset_line got=%h exp=0", line0); end
    checks++; if (tag0 !== 9'd0) begin failures++; $display("FAIL reset_tag got=%h exp=0", tag0); end
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", busy0, busy1); end
  endtask

  task automatic test_basic_fill();
    int lat = -1;
    int hi = 0;
    logic [127:0] gl = '0;
    logic [8:0] gt = '0;
    present_miss(5'b01110, 7'h11);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy_wait got=%b exp=1", busy0); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (wd0 === 1'b1) begin
        if (lat < 0) begin lat = i; gl = line0; gt = tag0; end
        hi++;
      end
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (hi !== 1) begin failures++; $display("FAIL basic_pulse_width got=%0d exp=1", hi); end
    checks++; if (gl !== {32'd15, 32'd14, 32'd13, 32'd12}) begin failures++; $display("FAIL basic_line got=%h exp=%h", gl, {32'd15, 32'd14, 32'd13, 32'd12}); end
    checks++; if (gt !== 9'h00D) begin failures++; $display("FAIL basic_tag got=%h exp=00d", gt); end
    checks++; if (line0 !== {32'd15, 32'd14, 32'd13, 32'd12}) begin failures++; $display("FAIL basic_line_hold got=%h", line0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL basic_busy_idle got=%b exp=0", busy0); end
  endtask

  task automatic test_ignored_ops();
    logic [6:0] ops [2];
    ops[0] = 7'h3F; ops[1] = 7'h13;
    for (int j = 0; j < 2; j++) begin
      int seen = 0;
      miss_addr = 5'b01110; mem_op = ops[j]; dcache_miss = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (busy0 !== 1'b0 || wd0 !== 1'b0) seen++;
      end
      dcache_miss = 1'b0; mem_op = 7'h3F;
      checks++; if (seen !== 0) begin failures++; $display("FAIL ignored_op_%h active_cycles got=%0d exp=0", ops[j], seen); end
    end
  endtask

  task automatic test_store_merge();
    logic [127:0] gl = '0;
    int lat = -1;
    present_miss(5'b01110, 7'h11);
    st_valid = 1'b1; st_addr = 5'd13; st_data = 32'hDEADBEEF;
    tick();
    st_valid = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (wd0 === 1'b1 && lat < 0) begin lat = i; gl = line0; end
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL store_wait_latency got=%0d exp=4", lat); end
    checks++; if (gl !== {32'd15, 32'd14, 32'hDEADBEEF, 32'd12}) begin failures++; $display("FAIL store_wait_line got=%h", gl); end

    present_miss(5'b01110, 7'h11);
    st_valid = 1'b1; st_addr = 5'd20; st_data = 32'h55AA55AA;
    tick();
    st_valid = 1'b0;
    tick(); tick();
    st_valid = 1'b1; st_addr = 5'd14; st_data = 32'hCAFEF00D;
    tick();
    st_valid = 1'b0;
    checks++; if (wd0 !== 1'b1) begin failures++; $display("FAIL store_merge_strobe got=%b exp=1", wd0); end
    checks++; if (line0 !== {32'd15, 32'hCAFEF00D, 32'hDEADBEEF, 32'd12}) begin failures++; $display("FAIL store_merge_line got=%h", line0); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_miss_hold();
    int fa = -1, fb = -1, gap_idle = 0;
    logic [127:0] la = '0, lb = '0;
    logic [8:0] ta = '0, tb = '0;
    miss_addr = 5'b01110; mem_op = 7'h11; dcache_miss = 1'b1;
    tick();
    miss_addr = 5'b00000; mem_op = 7'h10;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (fa >= 0 && fb < 0 && busy0 === 1'b0) gap_idle++;
      if (wd0 === 1'b1) begin
        if (fa < 0) begin fa = i; la = line0; ta = tag0; end
        else if (fb < 0) begin fb = i; lb = line0; tb = tag0; dcache_miss = 1'b0; mem_op = 7'h3F; break; end
      end
    end
    dcache_miss = 1'b0; mem_op = 7'h3F;
    checks++; if (fa !== 4) begin failures++; $display("FAIL hold_first_latency got=%0d exp=4", fa); end
    checks++; if (la !== {32'd15, 32'hCAFEF00D, 32'hDEADBEEF, 32'd12} || ta !== 9'h00D) begin failures++; $display("FAIL hold_first_fill line=%h tag=%h", la, ta); end
    checks++; if (fb !== 10) begin failures++; $display("FAIL hold_back_to_back got=%0d exp=10", fb); end
    checks++; if (gap_idle !== 1) begin failures++; $display("FAIL hold_idle_gap got=%0d exp=1", gap_idle); end
    checks++; if (lb !== {32'd3, 32'd2, 32'd1, 32'd0} || tb !== 9'h001) begin failures++; $display("FAIL hold_second_fill line=%h tag=%h", lb, tb); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat = -1;
    logic [127:0] gl = '0;
    present_miss(5'b01110, 7'h11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy0); end
    checks++; if (line0 !== 128'd0 || tag0 !== 9'd0) begin failures++; $display("FAIL rstmid_outputs line=%h tag=%h", line0, tag0); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wd0 !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_fill got=%0d exp=0", seen); end
    present_miss(5'b01110, 7'h11);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (wd0 === 1'b1 && lat < 0) begin lat = i; gl = line0; end
    end
    checks++; if (gl !== {32'd15, 32'd14, 32'd13, 32'd12}) begin failures++; $display("FAIL rstmid_mem_restored got=%h", gl); end
  endtask

  task automatic test_latency1();
    int lat = -1, bc = 0;
    logic [127:0] gl = '0;
    logic [8:0] gt = '0;
    present_miss(5'b00100, 7'h11);
    if (busy1 === 1'b1) bc++;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (busy1 === 1'b1) bc++;
      if (wd1 === 1'b1 && lat < 0) begin lat = i; gl = line1; gt = tag1; end
    end
    checks++; if (lat !== 1) begin failures++; $display("FAIL lat1_distance got=%0d exp=1", lat); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL lat1_busy_cycles got=%0d exp=2", bc); end
    checks++; if (gl !== {32'd7, 32'd6, 32'd5, 32'd4} || gt !== 9'h005) begin failures++; $display("FAIL lat1_fill line=%h tag=%h", gl, gt); end
  endtask

  initial begin
    rst = 1'b1; mem_op = 7'h3F; dcache_miss = 1'b0; miss_addr = '0;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    test_reset();
    test_basic_fill();
    test_ignored_ops();
    test_store_merge();
    test_miss_hold();
    test_reset_mid();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
